program_counter: RTL and testbench

//   Fetch-stage program counter. Drives the 10-bit instruction address into the

---
 rtl/program_counter.sv | 92 +++++++++
 tb/tb_program_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Fetch-stage program counter: start/run/halt sequencing with stall, absolute
// jump and PC-relative branch redirects, plus a saturating retired-instruction count.
//
// state  | meaning
// IDLE   | out of reset, pc parked, waiting for start
// RUN    | fetching; pc advances, redirects or holds each cycle
// HALTED | halt retired; pc and retired frozen until start
module program_counter #(
    parameter int PC_W     = 10,
    parameter int OFF_W    = 6,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             stall,
    input  logic             jump_en,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             branch_en,
    input  logic [OFF_W-1:0] branch_off,
    input  logic             halt,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_valid,
    output logic             done,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [CNT_W-1:0]  retired_nxt;
    logic [CNT_W-1:0]  retired_inc;
    logic [PC_W-1:0]   branch_sext;

    assign branch_sext = {{(PC_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
    assign retired_inc = (&retired) ? retired : retired + CNT_W'(1);

    assign fetch_valid = (state == RUN);
    assign done        = (state == HALTED);

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        retired_nxt = retired;
        unique case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_nxt   = RUN;
                    pc_nxt      = start_addr;
                    retired_nxt = '0;
                end
            end
            RUN: begin
                // the halt instruction itself retires unless stalled
                if (!stall) retired_nxt = retired_inc;
                if (halt) begin
                    state_nxt = HALTED;
                end else if (!stall) begin
                    if (jump_en)        pc_nxt = jump_target;
                    else if (branch_en) pc_nxt = pc + branch_sext;
                    else                pc_nxt = pc + PC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= RESET_PC_V;
            retired <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            retired <= retired_nxt;
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: a behavioural model pushes the expected
// outputs per driven cycle, popped and compared one cycle later.
module tb_program_counter;

    localparam int PC_W  = 10;
    localparam int OFF_W = 6;
    localparam int CNT_W = 4;  // narrow counter so saturation is reachable

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [PC_W-1:0]  start_addr = '0;
    logic             stall = 1'b0;
    logic             jump_en = 1'b0;
    logic [PC_W-1:0]  jump_target = '0;
    logic             branch_en = 1'b0;
    logic [OFF_W-1:0] branch_off = '0;
    logic             halt = 1'b0;
    logic [PC_W-1:0]  pc;
    logic             fetch_valid;
    logic             done;
    logic [CNT_W-1:0] retired;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             fv;
        logic             done;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // model: 0 idle, 1 run, 2 halted
    int               m_state = 0;
    logic [PC_W-1:0]  m_pc = '0;
    logic [CNT_W-1:0] m_ret = '0;

    program_counter #(
        .PC_W(PC_W), .OFF_W(OFF_W), .RESET_PC(0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .stall(stall), .jump_en(jump_en), .jump_target(jump_target),
        .branch_en(branch_en), .branch_off(branch_off), .halt(halt),
        .pc(pc), .fetch_valid(fetch_valid), .done(done), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        reset = 1'b0; start = 1'b0; stall = 1'b0; jump_en = 1'b0;
        branch_en = 1'b0; halt = 1'b0;
    endtask

    task automatic model_step();
        logic [PC_W-1:0] off_ext;
        off_ext = {{(PC_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
        if (reset) begin
            m_state = 0; m_pc = '0; m_ret = '0;
        end else if (m_state == 1) begin
            if (!stall && m_ret != {CNT_W{1'b1}}) m_ret = m_ret + 1'b1;
            if (halt)           m_state = 2;
            else if (stall)     m_pc = m_pc;
            else if (jump_en)   m_pc = jump_target;
            else if (branch_en) m_pc = m_pc + off_ext;
            else                m_pc = m_pc + 1'b1;
        end else if (start) begin
            m_state = 1; m_pc = start_addr; m_ret = '0;
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e.pc = m_pc; e.fv = (m_state == 1); e.done = (m_state == 2); e.ret = m_ret;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("sb_pc", 32'(pc), 32'(e.pc));
            check("sb_fetch_valid", 32'(fetch_valid), 32'(e.fv));
            check("sb_done", 32'(done), 32'(e.done));
            check("sb_retired", 32'(retired), 32'(e.ret));
        end
    endtask

    task automatic do_jump(input logic [PC_W-1:0] t);
        clear_inputs(); jump_en = 1'b1; jump_target = t; tick(); clear_inputs();
    endtask

    initial begin
        logic [CNT_W-1:0] ret_hold;

        // reset state
        reset = 1'b1; tick(); tick();
        check("rst_pc", 32'(pc), 32'h000);
        check("rst_fv", 32'(fetch_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        clear_inputs(); tick();
        check("idle_pc_hold", 32'(pc), 32'h000);

        // start and free run
        start = 1'b1; start_addr = 10'h005; tick(); clear_inputs();
        check("start_pc", 32'(pc), 32'h005);
        check("start_fv", 32'(fetch_valid), 32'd1);
        repeat (3) tick();
        check("free_pc", 32'(pc), 32'h008);
        check("free_retired", 32'(retired), 32'd3);

        // upward wrap
        do_jump(10'h3FF);
        tick();
        check("wrap_pc", 32'(pc), 32'h000);
        check("wrap_fv", 32'(fetch_valid), 32'd1);

        // negative branches, including downward wrap
        do_jump(10'h010);
        branch_en = 1'b1; branch_off = 6'b111101; tick(); clear_inputs();
        check("br_m3_pc", 32'(pc), 32'h00D);
        do_jump(10'h002);
        branch_en = 1'b1; branch_off = 6'b111100; tick(); clear_inputs();
        check("br_m4_pc", 32'(pc), 32'h3FE);
        branch_en = 1'b1; branch_off = 6'd31; tick(); clear_inputs();
        check("br_p31_pc", 32'(pc), 32'h01D);

        // priority: jump over branch, stall over jump
        jump_en = 1'b1; jump_target = 10'h200; branch_en = 1'b1; branch_off = 6'd5;
        tick(); clear_inputs();
        check("jmp_over_br", 32'(pc), 32'h200);
        ret_hold = m_ret;
        stall = 1'b1; jump_en = 1'b1; jump_target = 10'h100; tick(); clear_inputs();
        check("stall_jmp_pc", 32'(pc), 32'h200);
        check("stall_jmp_ret", 32'(retired), 32'(ret_hold));

        // saturation of the retired count
        repeat (20) tick();
        check("ret_saturate", 32'(retired), 32'hF);

        // halt and frozen HALTED state
        do_jump(10'h020);
        halt = 1'b1; tick(); clear_inputs();
        check("halt_done", 32'(done), 32'd1);
        check("halt_fv", 32'(fetch_valid), 32'd0);
        check("halt_pc", 32'(pc), 32'h020);
        ret_hold = m_ret;
        for (int i = 0; i < 5; i++) begin
            halt = 1'(i[0]); stall = 1'(i[1]); jump_en = 1'b1; jump_target = 10'h155;
            branch_en = 1'b1; branch_off = 6'd7; tick();
        end
        clear_inputs();
        check("halted_pc", 32'(pc), 32'h020);
        check("halted_ret", 32'(retired), 32'(ret_hold));
        start = 1'b1; start_addr = 10'h000; tick(); clear_inputs();
        check("restart_pc", 32'(pc), 32'h000);
        check("restart_done", 32'(done), 32'd0);
        check("restart_ret", 32'(retired), 32'd0);

        // start ignored in RUN, reset mid-run
        do_jump(10'h120);
        start = 1'b1; start_addr = 10'h3C0; repeat (3) tick();
        check("start_in_run_pc", 32'(pc), 32'h123);
        reset = 1'b1; tick(); clear_inputs();
        check("midrst_pc", 32'(pc), 32'h000);
        check("midrst_fv", 32'(fetch_valid), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_ret", 32'(retired), 32'd0);
        tick();
        check("midrst_idle_pc", 32'(pc), 32'h000);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 49) == 0);
            start       = ($urandom_range(0, 5) == 0);
            start_addr  = PC_W'($urandom);
            stall       = ($urandom_range(0, 4) == 0);
            jump_en     = ($urandom_range(0, 5) == 0);
            jump_target = PC_W'($urandom);
            branch_en   = ($urandom_range(0, 3) == 0);
            branch_off  = OFF_W'($urandom);
            halt        = ($urandom_range(0, 19) == 0);
            tick();
        end
        clear_inputs();

        if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
